// File: rtl/song_loader.sv
// song_loader: parses framed song uploads (A5, LEN_H, LEN_L, N x {NH, NL} [, CK])
// from the UART byte stream into 12-bit note words and streams them to the
// note register file as sequential writes.
//
// Optional build macro: SONG_LOADER_CKSUM_EN
//   defined   - frame ends with an XOR checksum byte that must match to commit.
//   undefined - no checksum byte; the frame commits the cycle after its last write.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   rx_data/valid   received byte and its one-cycle strobe
//   wr_addr/data/en note-memory write port (wr_en is a one-cycle strobe)
//   song_len        note count of the last committed frame
//   last_byte       most recent received byte, for display
//   busy            frame in progress
//   done            one-cycle pulse on frame commit
//   err             sticky error, cleared by the next accepted 0xA5 header
module song_loader #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [15:0]       song_len,
  output logic [7:0]        last_byte,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_NOTE_H,
    S_NOTE_L
`ifdef SONG_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT - 1);
  localparam logic [15:0] LEN_MAX    = 16'(MAX_LEN);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [3:0]        nh_q, nh_d;
  logic [31:0]       timer_q, timer_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [15:0]       song_len_q, song_len_d;
  logic [7:0]        last_byte_q, last_byte_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       n_new;
`ifdef SONG_LOADER_CKSUM_EN
  logic [7:0]        ck_q, ck_d;
`else
  logic              pend_q, pend_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      nh_q        <= '0;
      timer_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      song_len_q  <= '0;
      last_byte_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef SONG_LOADER_CKSUM_EN
      ck_q        <= '0;
`else
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      nh_q        <= nh_d;
      timer_q     <= timer_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      song_len_q  <= song_len_d;
      last_byte_q <= last_byte_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef SONG_LOADER_CKSUM_EN
      ck_q        <= ck_d;
`else
      pend_q      <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    nh_d        = nh_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    song_len_d  = song_len_q;
    last_byte_d = last_byte_q;
    done_d      = 1'b0;
    err_d       = err_q;
    n_new       = {len_q[15:8], rx_data};
`ifdef SONG_LOADER_CKSUM_EN
    ck_d        = ck_q;
`else
    pend_d      = 1'b0;
`endif

    if (rx_valid) begin
      last_byte_d = rx_data;
    end

    if (rx_valid || (state_q == S_IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 32'd1;
    end

`ifndef SONG_LOADER_CKSUM_EN
    // Commit lands one cycle after the final write strobe.
    if (pend_q) begin
      song_len_d = len_q;
      done_d     = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == 8'hA5)) begin
          state_d = S_LEN_H;
          err_d   = 1'b0;
`ifdef SONG_LOADER_CKSUM_EN
          ck_d    = '0;
`endif
        end
      end
      S_LEN_H: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = S_LEN_L;
`ifdef SONG_LOADER_CKSUM_EN
          ck_d        = ck_q ^ rx_data;
`endif
        end
      end
      S_LEN_L: begin
        if (rx_valid) begin
          len_d = n_new;
          idx_d = '0;
`ifdef SONG_LOADER_CKSUM_EN
          ck_d  = ck_q ^ rx_data;
`endif
          if ((n_new == 16'd0) || (n_new > LEN_MAX)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NOTE_H;
          end
        end
      end
      S_NOTE_H: begin
        if (rx_valid) begin
          nh_d    = rx_data[3:0];
          state_d = S_NOTE_L;
`ifdef SONG_LOADER_CKSUM_EN
          ck_d    = ck_q ^ rx_data;
`endif
        end
      end
      S_NOTE_L: begin
        if (rx_valid) begin
          // The write is registered, so leaving NOTE_L on the NL strobe itself
          // keeps back-to-back bytes lossless.
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(idx_q);
          wr_data_d = DATA_W'({nh_q, rx_data});
          idx_d     = idx_q + 16'd1;
`ifdef SONG_LOADER_CKSUM_EN
          ck_d      = ck_q ^ rx_data;
`endif
          if (idx_q == (len_q - 16'd1)) begin
`ifdef SONG_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_IDLE;
            pend_d  = 1'b1;
`endif
          end else begin
            state_d = S_NOTE_H;
          end
        end
      end
`ifdef SONG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (rx_valid) begin
          if (rx_data == ck_q) begin
            song_len_d = len_q;
            done_d     = 1'b1;
          end else begin
            err_d      = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && !rx_valid && (timer_q == TIMER_LAST)) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
      timer_d = '0;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign song_len  = song_len_q;
  assign last_byte = last_byte_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_song_loader.sv
module tb_song_loader;

  localparam int unsigned TO   = 40;
  localparam int unsigned MAXN = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_en;
  logic [15:0] song_len;
  logic [7:0]  last_byte;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  song_loader #(
    .ADDR_W (16),
    .DATA_W (12),
    .MAX_LEN(MAXN),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .song_len (song_len),
    .last_byte(last_byte),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: tracks position inside the frame rather than a state
  // machine; m_* hold the outputs expected after each clock edge.
  int          m_pos    = -1;
  int          m_n      = 0;
  int          m_silent = 0;
  logic [7:0]  m_x      = '0;
  logic [3:0]  m_nh     = '0;
  bit          m_pend   = 1'b0;
  bit          m_wr_en  = 1'b0;
  int          m_wr_addr = 0;
  logic [11:0] m_wr_data = '0;
  int          m_song_len = 0;
  logic [7:0]  m_last   = '0;
  bit          m_done   = 1'b0;
  bit          m_err    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1; m_n = 0; m_silent = 0; m_x = '0; m_nh = '0; m_pend = 1'b0;
      m_wr_en = 1'b0; m_wr_addr = 0; m_wr_data = '0; m_song_len = 0;
      m_last = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_wr_en = 1'b0;
      m_done  = 1'b0;
      if (m_pend) begin
        m_song_len = m_n;
        m_done     = 1'b1;
        m_pend     = 1'b0;
      end
      if (rx_valid) begin
        m_last   = rx_data;
        m_silent = 0;
        if (m_pos < 0) begin
          if (rx_data == 8'hA5) begin
            m_pos = 0; m_err = 1'b0; m_x = '0;
          end
        end else if (m_pos == 0) begin
          m_n = int'(rx_data) * 256;
          m_x = m_x ^ rx_data;
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_n = m_n + int'(rx_data);
          m_x = m_x ^ rx_data;
          if (m_n == 0 || m_n > int'(MAXN)) begin
            m_err = 1'b1; m_pos = -1;
          end else begin
            m_pos = 2;
          end
        end else if (m_pos < 2 + 2 * m_n) begin
          m_x = m_x ^ rx_data;
          if (m_pos % 2 == 0) begin
            m_nh  = rx_data[3:0];
            m_pos = m_pos + 1;
          end else begin
            m_wr_en   = 1'b1;
            m_wr_addr = (m_pos - 3) / 2;
            m_wr_data = {m_nh, rx_data};
            if (m_pos == 1 + 2 * m_n) begin
`ifdef SONG_LOADER_CKSUM_EN
              m_pos = m_pos + 1;
`else
              m_pos  = -1;
              m_pend = 1'b1;
`endif
            end else begin
              m_pos = m_pos + 1;
            end
          end
        end else begin
          if (rx_data == m_x) begin
            m_song_len = m_n;
            m_done     = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_pos = -1;
        end
      end else if (m_pos >= 0) begin
        m_silent = m_silent + 1;
        if (m_silent == int'(TO)) begin
          m_err = 1'b1; m_pos = -1; m_silent = 0;
        end
      end
    end
  end

  logic [31:0] wlog[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      chk("wr_data", 32'(wr_data), 32'(m_wr_data));
    end
    chk("song_len", 32'(song_len), 32'(m_song_len));
    chk("last_byte", 32'(last_byte), 32'(m_last));
    chk("busy", 32'(busy), 32'(m_pos >= 0));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    if (wr_en === 1'b1) wlog.push_back({4'h0, wr_addr, wr_data});
    if (done === 1'b1) done_cnt++;
  end

  task automatic put(input logic [7:0] b, input logic v);
    rx_data  = b;
    rx_valid = v;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) put(8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] q[$], input int gap);
    foreach (q[i]) begin
      put(q[i], 1'b1);
      idle(gap);
    end
  endtask

  task automatic clear_logs();
    wlog.delete();
    done_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_song_len", 32'(song_len), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_last_byte", 32'(last_byte), 32'h0);
    rst = 1'b0;
    idle(2);

    // Two-note frame, one idle cycle between bytes. XOR of body = 0xD0.
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF};
`ifdef SONG_LOADER_CKSUM_EN
    q.push_back(8'hD0);
`endif
    send(q, 1);
    idle(3);
    chk("t1_nwrites", 32'(wlog.size()), 32'd2);
    chk("t1_write0", wlog[0], 32'h0000123);
    chk("t1_write1", wlog[1], 32'h0001FFF);
    chk("t1_song_len", 32'(song_len), 32'd2);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

`ifdef SONG_LOADER_CKSUM_EN
    // Same frame with a bad checksum after reset.
    rst = 1'b1; idle(1); rst = 1'b0;
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00};
    send(q, 1);
    idle(3);
    chk("t2_nwrites", 32'(wlog.size()), 32'd2);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_song_len", 32'(song_len), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'd0);
`endif

    // Length bounds: N = 0 and N = 1025.
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h00};
    send(q, 0);
    idle(2);
    chk("t3_zero_err", 32'(err), 32'd1);
    chk("t3_zero_busy", 32'(busy), 32'd0);
    q = '{8'hA5, 8'h04, 8'h01};
    send(q, 0);
    idle(2);
    chk("t3_big_err", 32'(err), 32'd1);
    chk("t3_big_busy", 32'(busy), 32'd0);
    chk("t3_nwrites", 32'(wlog.size()), 32'd0);

    // Timeout after a partial frame.
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h23, 8'h0F};
    send(q, 0);
    idle(TO - 1);
    chk("t4_busy_before", 32'(busy), 32'd1);
    chk("t4_err_before", 32'(err), 32'd0);
    idle(1);
    chk("t4_busy_expired", 32'(busy), 32'd0);
    chk("t4_err_expired", 32'(err), 32'd1);
    chk("t4_nwrites", 32'(wlog.size()), 32'd1);
    chk("t4_write0", wlog[0], 32'h0000123);

    // Byte arriving on the expiry cycle keeps the frame alive.
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23};
    send(q, 0);
    idle(TO - 1);
    q = '{8'h0F, 8'hFF};
`ifdef SONG_LOADER_CKSUM_EN
    q.push_back(8'hD0);
`endif
    send(q, 0);
    idle(3);
    chk("t4b_nwrites", 32'(wlog.size()), 32'd2);
    chk("t4b_done_cnt", 32'(done_cnt), 32'd1);
    chk("t4b_err", 32'(err), 32'd0);
    chk("t4b_song_len", 32'(song_len), 32'd2);

    // Reset mid-frame, then a clean one-note frame. XOR of body = 0xB7.
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h23};
    send(q, 0);
    idle(1);
    rst = 1'b1;
    idle(1);
    chk("t5_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t5_rst_wr_data", 32'(wr_data), 32'd0);
    chk("t5_rst_song_len", 32'(song_len), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_err", 32'(err), 32'd0);
    chk("t5_rst_last_byte", 32'(last_byte), 32'd0);
    rst = 1'b0;
    idle(1);
    chk("t5_nwrites_pre", 32'(wlog.size()), 32'd1);
    clear_logs();
    q = '{8'hA5, 8'h00, 8'h01, 8'h0A, 8'hBC};
`ifdef SONG_LOADER_CKSUM_EN
    q.push_back(8'hB7);
`endif
    send(q, 1);
    idle(3);
    chk("t5_nwrites", 32'(wlog.size()), 32'd1);
    chk("t5_write0", wlog[0], 32'h0000ABC);
    chk("t5_song_len", 32'(song_len), 32'd1);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Garbage before the header, then a back-to-back frame.
    clear_logs();
    q = '{8'h00, 8'hFF, 8'h5A};
    send(q, 0);
    chk("t6_garbage_last", 32'(last_byte), 32'h5A);
    chk("t6_garbage_busy", 32'(busy), 32'd0);
    q = '{8'hA5, 8'h00, 8'h01, 8'h0A, 8'hBC};
`ifdef SONG_LOADER_CKSUM_EN
    q.push_back(8'hB7);
`endif
    send(q, 0);
    idle(3);
`ifdef SONG_LOADER_CKSUM_EN
    chk("t6_last_byte", 32'(last_byte), 32'hB7);
`else
    chk("t6_last_byte", 32'(last_byte), 32'hBC);
`endif
    chk("t6_nwrites", 32'(wlog.size()), 32'd1);
    chk("t6_write0", wlog[0], 32'h0000ABC);
    chk("t6_song_len", 32'(song_len), 32'd1);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
